// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - 4-digit common-anode 7-segment scan controller
//
// Purpose:
//   Time-multiplexes a 16-bit hex word onto four 7-segment digits. Each digit
//   owns a slot of DIV clocks. The first BLANK clocks of every slot are dark so
//   the previous digit's pattern cannot ghost onto the next anode. New data goes
//   into a shadow register and is only promoted to the displayed (active) set at
//   a frame boundary, so a single frame never mixes old and new digits.
//
// Ports:
//   clk         in   1   system clock
//   reset       in   1   synchronous, active-high reset
//   load        in   1   1-cycle strobe capturing value/dig_en/dp_in
//   value       in   16  digit3..digit0 = value[15:12]..value[3:0]
//   dig_en      in   4   per-digit enable, 0 = digit always dark
//   dp_in       in   4   per-digit decimal point, active high
//   seg7        out  7   cathodes ABCDEFG, active low, bit6 = A
//   dp          out  1   decimal-point cathode, active low
//   an          out  4   anodes, active low, at most one low
//   pending     out  1   shadow data waiting for the next frame boundary
//   frame_done  out  1   1-cycle pulse after each completed frame

module seg7_scan_ctrl #(
  parameter int DIV   = 100000,
  parameter int BLANK = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dig_en,
  input  logic [3:0]  dp_in,
  output logic [6:0]  seg7,
  output logic        dp,
  output logic [3:0]  an,
  output logic        pending,
  output logic        frame_done
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;

  logic [15:0]   act_value;
  logic [3:0]    act_en;
  logic [3:0]    act_dp;
  logic [15:0]   sh_value;
  logic [3:0]    sh_en;
  logic [3:0]    sh_dp;

  logic          slot_end;
  logic          boundary;

  assign slot_end = (cnt == CNT_MAX);
  assign boundary = slot_end && (idx == 2'd3);

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= 2'd0;
      act_value  <= 16'h0000;
      act_en     <= 4'b0000;
      act_dp     <= 4'b0000;
      sh_value   <= 16'h0000;
      sh_en      <= 4'b0000;
      sh_dp      <= 4'b0000;
      pending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      cnt        <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end) begin
        idx <= idx + 2'd1;
      end
      frame_done <= boundary;

      if (boundary) begin
        // A load landing on the boundary itself is newer than anything held
        // in the shadow, so it goes straight to the active set.
        if (load) begin
          act_value <= value;
          act_en    <= dig_en;
          act_dp    <= dp_in;
        end else if (pending) begin
          act_value <= sh_value;
          act_en    <= sh_en;
          act_dp    <= sh_dp;
        end
        pending <= 1'b0;
      end else if (load) begin
        sh_value <= value;
        sh_en    <= dig_en;
        sh_dp    <= dp_in;
        pending  <= 1'b1;
      end
    end
  end

  // Outputs depend only on registered state.
  logic [3:0] nib;
  logic       show;

  always_comb begin
    nib  = act_value[{idx, 2'b00} +: 4];
    show = (cnt >= BLANK_C) && act_en[idx];
    an   = 4'b1111;
    seg7 = 7'b1111111;
    dp   = 1'b1;
    if (show) begin
      an   = ~(4'b0001 << idx);
      seg7 = decode(nib);
      dp   = ~act_dp[idx];
    end
  end

endmodule
